// File: rtl/shift_request_stage.sv
// Request queue in front of an external combinational funnel shifter, with a
// registered result stage. Queue head drives the shifter; its result is loaded into out_y.
module shift_request_stage #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [4:0]               in_shamt,
  input  logic [2:0]               in_control,
  output logic [31:0]              sh_a,
  output logic [4:0]               sh_shamt,
  output logic [2:0]               sh_control,
  input  logic [31:0]              sh_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_y,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef struct packed {
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [2:0]  control;
  } req_t;

  req_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          load;
  logic          not_empty;

  assign not_empty = (level != '0);
  // in_ready deliberately ignores a same-cycle pop so a full queue never accepts
  assign in_ready  = (level < FULL_LEVEL) && rst_n;
  assign push      = in_valid && in_ready;
  assign load      = not_empty && (!out_valid || out_ready);

  always_comb begin
    sh_a       = '0;
    sh_shamt   = '0;
    sh_control = '0;
    if (not_empty) begin
      sh_a       = mem[rd_ptr].a;
      sh_shamt   = mem[rd_ptr].shamt;
      sh_control = mem[rd_ptr].control;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: in_a, shamt: in_shamt, control: in_control};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (load) begin
        rd_ptr    <= rd_ptr + PW'(1);
        out_y     <= sh_y;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case ({push, load})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_request_stage.sv
// Scoreboard bench: an input monitor queues expected results at accepted pushes,
// an output monitor pops and compares each result the DUT presents.
module tb_shift_request_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [4:0]  in_shamt;
  logic [2:0]  in_control;
  logic [31:0] sh_a;
  logic [4:0]  sh_shamt;
  logic [2:0]  sh_control;
  logic [31:0] sh_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        seen;
  logic [31:0] held;

  shift_request_stage #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_shamt(in_shamt), .in_control(in_control),
    .sh_a(sh_a), .sh_shamt(sh_shamt), .sh_control(sh_control), .sh_y(sh_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .level(level)
  );

  always #5 clk = ~clk;

  // Environment stand-in for funnel_shifter_32: one bit position per iteration.
  function automatic logic [31:0] env_shift(input logic [31:0] a, input logic [4:0] s,
                                            input logic [2:0] c);
    logic [31:0] r;
    r = a;
    for (int i = 0; i < int'(s); i++) begin
      casez (c)
        3'b000:  r = {1'b0, r[31:1]};
        3'b001:  r = {r[31], r[31:1]};
        3'b010:  r = {r[0], r[31:1]};
        3'b011:  r = {r[30:0], r[31]};
        default: r = {r[30:0], 1'b0};
      endcase
    end
    return r;
  endfunction

  // Reference opcode semantics written with whole-word operators.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                            input logic [2:0] c);
    logic [63:0] d;
    logic [31:0] r;
    d = {a, a};
    casez (c)
      3'b000:  r = a >> s;
      3'b001:  r = $signed(a) >>> s;
      3'b010:  begin d = d >> s; r = d[31:0]; end
      3'b011:  begin d = d << s; r = d[63:32]; end
      default: r = a << s;
    endcase
    return r;
  endfunction

  always_comb sh_y = env_shift(sh_a, sh_shamt, sh_control);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Input monitor: an accepted request becomes an expected result.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready)
      exp_q.push_back(ref_shift(in_a, in_shamt, in_control));
  end

  // Output monitor: each new result is compared once, then held stable until taken.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got 0x%08h expected no result at %0t", out_y, $time);
        end else begin
          chk("sb_result", out_y, exp_q.pop_front());
        end
        held = out_y;
        seen = 1'b1;
      end else begin
        chk("sb_hold", out_y, held);
      end
      if (out_ready) seen = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (level == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [2:0]  ctls [4] = '{3'b000, 3'b001, 3'b100, 3'b010};
  logic [31:0] exps [4] = '{32'h0FE00002, 32'hFFE00002, 32'hE0000210, 32'h1FE00002};

  initial begin
    int acc;
    logic [31:0] a0;
    logic [17:0] ovs;
    int maxlvl;
    seen = 1'b0;
    held = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_shamt = '0; in_control = '0;
    step(); step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", out_y, 32'd0);
    chk("rst_sh_a", sh_a, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // single requests per opcode, two-cycle latency
    for (int k = 0; k < 4; k++) begin
      drain();
      in_a = 32'hFE000021; in_shamt = 5'd4; in_control = ctls[k];
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("lat_e0_valid", 32'(out_valid), 32'd0);
      step();
      chk("lat_e1_valid", 32'(out_valid), 32'd1);
      chk("opcode_out_y", out_y, exps[k]);
    end

    // back-pressure: six offers, five accepted
    drain();
    out_ready = 1'b0; a0 = 32'h8765_4321; in_a = a0; in_control = 3'b011;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_shamt = 5'(i);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_level", 32'(level), 32'd4);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_y", out_y, ref_shift(a0, 5'd0, 3'b011));
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rel_valid", 32'(out_valid), 32'd1);
      chk("bp_rel_y", out_y, ref_shift(a0, 5'(i), 3'b011));
      step();
    end
    chk("bp_rel_empty", 32'(out_valid), 32'd0);

    // full plus pop: offer is refused, level drops by one
    drain();
    out_ready = 1'b0; in_a = 32'h1234_5678; in_control = 3'b000;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_shamt = 5'(i + 1);
      step();
    end
    chk("fp_level_full", 32'(level), 32'd4);
    in_a = 32'hDEAD_BEEF; in_valid = 1'b1; out_ready = 1'b1;
    chk("fp_in_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    chk("fp_level", 32'(level), 32'd3);

    // streaming: 16 back-to-back requests
    drain();
    ovs = '0; maxlvl = 0;
    for (int i = 0; i < 18; i++) begin
      in_valid = (i < 16);
      in_a = $urandom; in_shamt = 5'($urandom); in_control = 3'($urandom);
      step();
      ovs[i] = out_valid;
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    in_valid = 1'b0;
    chk("stream_valid_run", 32'(ovs), 32'h1FFFE);
    chk("stream_max_level", 32'(maxlvl), 32'd1);

    // reset mid-operation
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_shamt = 5'($urandom); in_control = 3'($urandom);
      step();
    end
    in_valid = 1'b0;
    chk("mr_level_pre", 32'(level), 32'd3);
    chk("mr_valid_pre", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_level", 32'(level), 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_out_y", out_y, 32'd0);
    out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) acc++;
    end
    chk("mr_no_stale", 32'(acc), 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      in_a       = $urandom;
      in_shamt   = 5'($urandom);
      in_control = 3'($urandom);
      step();
    end
    drain();
    step();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_request_stage.md
SHIFT_REQUEST_STAGE -- requirements
Module: shift_request_stage

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, request-queue entries (power of 2, >= 2).
REQ-002 The port list SHALL be as follows (one port per line).
- clk  in  1  sole clock, rising-edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- in_a  in  32  operand.
- in_shamt  in  5  shift amount, 0..31.
- in_control  in  3  funnel-shifter opcode, passed through unmodified.
- sh_a  out  32  queue-head operand, to funnel_shifter_32 a.
- sh_shamt  out  5  queue-head shift amount, to funnel_shifter_32 shamt.
- sh_control  out  3  queue-head opcode, to funnel_shifter_32 control.
- sh_y  in  32  combinational result from funnel_shifter_32 y.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer accepts the result.
- out_y  out  32  registered shift result.
- level  out  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-003 Push SHALL occur on a rising edge where in_valid && in_ready; {in_a, in_shamt, in_control} is written at the write pointer.
REQ-004 in_ready SHALL be (level < DEPTH) && rst_n; it SHALL NOT depend on a same-cycle pop.
REQ-005 When level > 0, sh_a/sh_shamt/sh_control SHALL drive the entry at the read pointer; when level == 0 they SHALL drive 0.
REQ-006 Load SHALL occur on a rising edge where level > 0 && (!out_valid || out_ready): out_y <= sh_y, out_valid <= 1, queue head popped.
REQ-007 On an edge where out_valid && out_ready and level == 0, out_valid SHALL go to 0 and out_y SHALL hold.
REQ-008 While out_valid && !out_ready, out_y and out_valid SHALL remain stable.
REQ-009 Simultaneous push and pop SHALL leave level unchanged; push only gives level+1; pop only gives level-1.
REQ-010 Read and write pointers SHALL wrap modulo DEPTH.
REQ-011 Results SHALL leave in strict request order, with no loss or duplication.
REQ-012 Latency SHALL be 2 cycles: a request pushed on edge E0 into an empty, non-stalled block SHALL appear as out_valid/out_y after edge E1.
REQ-013 Sustained throughput SHALL be one result per cycle when out_ready is held at 1.
REQ-014 A push attempt while full SHALL be ignored (in_ready = 0), even if a pop occurs on the same edge.
REQ-015 Capacity SHALL be DEPTH queued entries plus 1 in the result register.

Reset
REQ-016 On a rising edge with rst_n == 0, the following SHALL occur.
- level = 0, both pointers = 0.
- out_valid = 0, out_y = 0.
- All queued requests and any held result discarded.
REQ-017 in_ready SHALL be 0 while rst_n == 0 and 1 on the first cycle after reset release.
REQ-018 Queue storage contents SHALL NOT require a reset.

Verification
REQ-019 Single requests, each with a = 0xFE000021, shamt = 4 and out_ready = 1, SHALL produce out_y 2 cycles after the push, per opcode.
- control 000 -> out_y = 0x0FE00002.
- control 001 -> out_y = 0xFFE00002.
- control 100 -> out_y = 0xE0000210.
- control 010 -> out_y = 0x1FE00002.
REQ-020 Back-pressure (DEPTH = 4): hold out_ready = 0 and offer 6 requests with shamt = 0..5 on consecutive cycles. Required response:
- 5 requests accepted; in_ready = 0 after the 5th; level = 4.
- out_y = result for shamt 0, held stable.
- After releasing out_ready, 5 results emerge in order on consecutive cycles, then out_valid = 0.
REQ-021 Streaming: 16 back-to-back requests with out_ready = 1 SHALL produce 16 consecutive out_valid cycles, level <= 1 throughout, and correct in-order results.
REQ-022 Full plus pop: with level = 4 and out_ready = 1, in_valid = 1 SHALL push nothing on that edge, and level SHALL become 3.
REQ-023 Reset mid-operation: with 3 queued requests and out_valid = 1, one cycle of rst_n = 0 SHALL give level = 0, out_valid = 0 and out_y = 0, and no stale result SHALL appear afterwards.
REQ-024 The bench SHALL check every out_y against a reference model of the opcode semantics: 000 >>, 001 >>>, 010 ROR, 011 ROL, 1xx <<.
